// File: rtl/mux_nx1_reg.sv
// N-input, WIDTH-bit multiplexer with valid/ready channels and a one-deep registered output.
// Grants come from an explicit select or a round-robin scan starting at rr_ptr.
module mux_nx1_reg #(
   parameter int unsigned N_INPUTS = 4,
   parameter int unsigned WIDTH    = 32,
   localparam int unsigned SEL_W   = $clog2(N_INPUTS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_INPUTS*WIDTH-1:0] in_data,
   input  logic [N_INPUTS-1:0]       in_valid,
   output logic [N_INPUTS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_src
);

   logic [WIDTH-1:0] out_data_d, out_data_q;
   logic             out_valid_d, out_valid_q;
   logic [SEL_W-1:0] out_src_d, out_src_q;
   logic [SEL_W-1:0] rr_ptr_d, rr_ptr_q;

   logic             can_load;
   logic             grant_found;
   logic [SEL_W-1:0] grant_idx;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;
   int unsigned      best_off;
   int unsigned      off;
   int unsigned      rr_int;

   assign can_load = !out_valid_q || out_ready;

   // Grant selection. In round-robin mode the channel with the smallest distance
   // (mod N_INPUTS) from rr_ptr wins, so indices >= N_INPUTS are never produced.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      best_off    = N_INPUTS;
      off         = 0;
      rr_int      = int'(rr_ptr_q);
      if (!mode) begin
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               grant_found = 1'b1;
               grant_idx   = SEL_W'(i);
            end
         end
      end else begin
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            off = (i >= rr_int) ? (i - rr_int) : (i + N_INPUTS - rr_int);
            if (in_valid[i] && off < best_off) begin
               best_off    = off;
               grant_found = 1'b1;
               grant_idx   = SEL_W'(i);
            end
         end
      end
   end

   assign xfer = grant_found && can_load;

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            in_ready[i] = rst_n && xfer;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_src_d   = grant_idx;
         out_valid_d = 1'b1;
         if (mode) begin
            rr_ptr_d = (int'(grant_idx) == N_INPUTS - 1) ? '0 : grant_idx + SEL_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_src   = out_src_q;

endmodule
